// File: rtl/cursor_move_controller_if.sv
// Button/strobe inputs and cursor outputs shared between the board buttons
// and the VGA square-overlay logic.
interface cursor_move_controller_if;
    logic       screen_end;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [3:0] cell_x;
    logic [3:0] cell_y;
    logic [9:0] x_topleft;
    logic [8:0] y_topleft;
    logic       moved;
    logic       held;

    modport master (
        output screen_end, up, down, left, right,
        input  cell_x, cell_y, x_topleft, y_topleft, moved, held
    );

    modport slave (
        input  screen_end, up, down, left, right,
        output cell_x, cell_y, x_topleft, y_topleft, moved, held
    );
endinterface

// File: rtl/cursor_move_controller.sv
// Tile-cursor motion sequencer: one cell step per frame at most, with
// press / hold-delay / auto-repeat timing and clamp or wrap at board edges.
module cursor_move_controller #(
    parameter int GRID_W       = 10,
    parameter int GRID_H       = 7,
    parameter int CELL_SIZE    = 64,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 6,
    parameter int WRAP         = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    cursor_move_controller_if.slave  bus
);

    localparam int SHIFT   = $clog2(CELL_SIZE);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
    localparam logic [3:0]    X_MAX      = 4'(GRID_W - 1);
    localparam logic [3:0]    Y_MAX      = 4'(GRID_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    // Button vectors are packed as {up, down, left, right}.
    logic [3:0]    btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic          se_meta_q, se_meta_d, se_sync_q, se_sync_d, se_prev_q, se_prev_d;
    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic [CW-1:0] frm_cnt_q, frm_cnt_d;
    logic [3:0]    cell_x_q, cell_x_d, cell_y_q, cell_y_d;
    logic [9:0]    x_tl_q, x_tl_d;
    logic [8:0]    y_tl_q, y_tl_d;
    logic          moved_q, moved_d, held_q, held_d;

    logic          frame_tick_s;
    dir_e          dir_sel_s;
    dir_e          step_dir_s;
    logic          latched_pressed_s;
    logic          step_s;

    // Synchronizer stages, frame-end edge detect and priority direction select
    always_comb begin
        btn_meta_d   = {bus.up, bus.down, bus.left, bus.right};
        btn_sync_d   = btn_meta_q;
        se_meta_d    = bus.screen_end;
        se_sync_d    = se_meta_q;
        se_prev_d    = se_sync_q;
        frame_tick_s = se_sync_q & ~se_prev_q;
        if (btn_sync_q[3]) begin
            dir_sel_s = DIR_UP;
        end else if (btn_sync_q[2]) begin
            dir_sel_s = DIR_DOWN;
        end else if (btn_sync_q[1]) begin
            dir_sel_s = DIR_LEFT;
        end else if (btn_sync_q[0]) begin
            dir_sel_s = DIR_RIGHT;
        end else begin
            dir_sel_s = DIR_NONE;
        end
    end

    // Is the button behind the latched direction still pressed?
    always_comb begin
        case (dir_q)
            DIR_UP:    latched_pressed_s = btn_sync_q[3];
            DIR_DOWN:  latched_pressed_s = btn_sync_q[2];
            DIR_LEFT:  latched_pressed_s = btn_sync_q[1];
            DIR_RIGHT: latched_pressed_s = btn_sync_q[0];
            default:   latched_pressed_s = 1'b0;
        endcase
    end

    // Press/hold/repeat sequencing; release acts on any clock, the rest on frame ticks
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        frm_cnt_d = frm_cnt_q;
        step_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick_s && (dir_sel_s != DIR_NONE)) begin
                    dir_d     = dir_sel_s;
                    step_s    = 1'b1;
                    frm_cnt_d = '0;
                    state_d   = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!latched_pressed_s) begin
                    state_d   = ST_IDLE;
                    frm_cnt_d = '0;
                end else if (frame_tick_s) begin
                    if (frm_cnt_q == DELAY_LAST) begin
                        step_s    = 1'b1;
                        frm_cnt_d = '0;
                        state_d   = ST_REPEAT;
                    end else begin
                        frm_cnt_d = frm_cnt_q + CW'(1);
                    end
                end else begin
                    frm_cnt_d = frm_cnt_q;
                end
            end
            ST_REPEAT: begin
                if (!latched_pressed_s) begin
                    state_d   = ST_IDLE;
                    frm_cnt_d = '0;
                end else if (frame_tick_s) begin
                    if (frm_cnt_q == RATE_LAST) begin
                        step_s    = 1'b1;
                        frm_cnt_d = '0;
                    end else begin
                        frm_cnt_d = frm_cnt_q + CW'(1);
                    end
                end else begin
                    frm_cnt_d = frm_cnt_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                frm_cnt_d = '0;
            end
        endcase
        if (state_q == ST_IDLE) begin
            step_dir_s = dir_sel_s;
        end else begin
            step_dir_s = dir_q;
        end
    end

    // Apply one step with clamp or wrap; moved only when the cell really changes
    always_comb begin
        cell_x_d = cell_x_q;
        cell_y_d = cell_y_q;
        if (step_s) begin
            case (step_dir_s)
                DIR_UP: begin
                    if (cell_y_q != 4'd0)   cell_y_d = cell_y_q - 4'd1;
                    else if (WRAP != 0)     cell_y_d = Y_MAX;
                    else                    cell_y_d = cell_y_q;
                end
                DIR_DOWN: begin
                    if (cell_y_q != Y_MAX)  cell_y_d = cell_y_q + 4'd1;
                    else if (WRAP != 0)     cell_y_d = 4'd0;
                    else                    cell_y_d = cell_y_q;
                end
                DIR_LEFT: begin
                    if (cell_x_q != 4'd0)   cell_x_d = cell_x_q - 4'd1;
                    else if (WRAP != 0)     cell_x_d = X_MAX;
                    else                    cell_x_d = cell_x_q;
                end
                DIR_RIGHT: begin
                    if (cell_x_q != X_MAX)  cell_x_d = cell_x_q + 4'd1;
                    else if (WRAP != 0)     cell_x_d = 4'd0;
                    else                    cell_x_d = cell_x_q;
                end
                default: begin
                    cell_x_d = cell_x_q;
                    cell_y_d = cell_y_q;
                end
            endcase
        end else begin
            cell_x_d = cell_x_q;
            cell_y_d = cell_y_q;
        end
        moved_d = (cell_x_d != cell_x_q) || (cell_y_d != cell_y_q);
        x_tl_d  = {6'd0, cell_x_d} << SHIFT;
        y_tl_d  = {5'd0, cell_y_d} << SHIFT;
        held_d  = (state_d != ST_IDLE);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= 4'd0;
            btn_sync_q <= 4'd0;
            se_meta_q  <= 1'b0;
            se_sync_q  <= 1'b0;
            se_prev_q  <= 1'b0;
            state_q    <= ST_IDLE;
            dir_q      <= DIR_NONE;
            frm_cnt_q  <= '0;
            cell_x_q   <= 4'd0;
            cell_y_q   <= 4'd0;
            x_tl_q     <= 10'd0;
            y_tl_q     <= 9'd0;
            moved_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            se_meta_q  <= se_meta_d;
            se_sync_q  <= se_sync_d;
            se_prev_q  <= se_prev_d;
            state_q    <= state_d;
            dir_q      <= dir_d;
            frm_cnt_q  <= frm_cnt_d;
            cell_x_q   <= cell_x_d;
            cell_y_q   <= cell_y_d;
            x_tl_q     <= x_tl_d;
            y_tl_q     <= y_tl_d;
            moved_q    <= moved_d;
            held_q     <= held_d;
        end
    end

    assign bus.cell_x    = cell_x_q;
    assign bus.cell_y    = cell_y_q;
    assign bus.x_topleft = x_tl_q;
    assign bus.y_topleft = y_tl_q;
    assign bus.moved     = moved_q;
    assign bus.held      = held_q;

endmodule

// File: tb/tb_cursor_move_controller.sv
// Drives a clamping and a wrapping instance with identical stimulus and checks
// both every cycle against a frame-counting reference model.
module tb_cursor_move_controller;

    localparam int GW = 10;
    localparam int GH = 7;
    localparam int RD = 20;
    localparam int RR = 6;
    localparam int FRAME_CLKS = 16;
    localparam bit [3:0] B_UP = 4'b1000, B_DN = 4'b0100, B_LT = 4'b0010, B_RT = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       se = 1'b0;
    logic [3:0] btn = 4'd0;

    int checks = 0;
    int errors = 0;
    int mv0 = 0;
    bit armed = 0;

    // Reference model state, index 0 = clamp instance, 1 = wrap instance
    int mx[2], my[2], mn[2], mdir[2];
    bit mact[2], mmov[2];
    bit [3:0] h1, h2, h3;
    bit s1, s2, s3;

    cursor_move_controller_if if0();
    cursor_move_controller_if if1();

    assign if0.screen_end = se;
    assign if0.up = btn[3];
    assign if0.down = btn[2];
    assign if0.left = btn[1];
    assign if0.right = btn[0];
    assign if1.screen_end = se;
    assign if1.up = btn[3];
    assign if1.down = btn[2];
    assign if1.left = btn[1];
    assign if1.right = btn[0];

    cursor_move_controller #(.WRAP(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    cursor_move_controller #(.WRAP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    function automatic int prio(input bit [3:0] b);
        if (b[3]) return 0;
        else if (b[2]) return 1;
        else if (b[1]) return 2;
        else if (b[0]) return 3;
        else return -1;
    endfunction

    function automatic bit btn_of(input bit [3:0] b, input int d);
        return b[3-d];
    endfunction

    // n = frame ticks seen since the press, counting the press frame as 1
    function automatic bit step_due(input int n);
        if (n == RD + 1) return 1'b1;
        else if (n > RD + 1 && ((n - RD - 1) % RR) == 0) return 1'b1;
        else return 1'b0;
    endfunction

    // Model sees inputs two clocks late (synchronizers) and ticks on their rising edge
    always @(posedge clk) begin : model
        bit tick, do_step;
        int nx, ny;
        if (reset) begin
            h1 = 0; h2 = 0; h3 = 0; s1 = 0; s2 = 0; s3 = 0;
            for (int w = 0; w < 2; w++) begin
                mx[w] = 0; my[w] = 0; mn[w] = 0; mdir[w] = 0; mact[w] = 0; mmov[w] = 0;
            end
            armed = 1;
        end else begin
            tick = s2 && !s3;
            for (int w = 0; w < 2; w++) begin
                mmov[w] = 0;
                do_step = 0;
                if (mact[w]) begin
                    if (!btn_of(h2, mdir[w])) begin
                        mact[w] = 0; mn[w] = 0;
                    end else if (tick) begin
                        mn[w]++;
                        do_step = step_due(mn[w]);
                    end
                end else if (tick && h2 != 0) begin
                    mdir[w] = prio(h2); mact[w] = 1; mn[w] = 1; do_step = 1;
                end
                if (do_step) begin
                    nx = mx[w]; ny = my[w];
                    case (mdir[w])
                        0: ny = ny - 1;
                        1: ny = ny + 1;
                        2: nx = nx - 1;
                        default: nx = nx + 1;
                    endcase
                    if (w == 1) begin
                        nx = (nx + GW) % GW; ny = (ny + GH) % GH;
                    end else begin
                        if (nx < 0) nx = 0;
                        if (nx > GW - 1) nx = GW - 1;
                        if (ny < 0) ny = 0;
                        if (ny > GH - 1) ny = GH - 1;
                    end
                    mmov[w] = (nx != mx[w]) || (ny != my[w]);
                    mx[w] = nx; my[w] = ny;
                end
            end
            h3 = h2; h2 = h1; h1 = btn; s3 = s2; s2 = s1; s1 = se;
        end
    end

    task automatic cmp(input int w, input logic [3:0] x, input logic [3:0] y,
                       input logic [9:0] xt, input logic [8:0] yt, input logic mv, input logic hd);
        logic [27:0] act, exp;
        act = {x, y, xt, yt, mv, hd};
        exp = {4'(mx[w]), 4'(my[w]), 10'(mx[w] * 64), 9'(my[w] * 64), mmov[w], mact[w]};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cmp_dut%0d t=%0t got x=%0d y=%0d xt=%0d yt=%0d mv=%b held=%b expected x=%0d y=%0d xt=%0d yt=%0d mv=%b held=%b",
                     w, $time, x, y, xt, yt, mv, hd, mx[w], my[w], mx[w] * 64, my[w] * 64, mmov[w], mact[w]);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (armed) begin
            cmp(0, if0.cell_x, if0.cell_y, if0.x_topleft, if0.y_topleft, if0.moved, if0.held);
            cmp(1, if1.cell_x, if1.cell_y, if1.x_topleft, if1.y_topleft, if1.moved, if1.held);
            if (if0.moved === 1'b1) mv0++;
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            w = $urandom_range(1, 4);
            se = 1'b1;
            repeat (w) @(negedge clk);
            se = 1'b0;
            repeat (FRAME_CLKS - w) @(negedge clk);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        settle(2);
        reset = 1'b0;
        lit("reset_x", int'(if0.cell_x), 0);
        lit("reset_yt", int'(if1.y_topleft), 0);
        lit("reset_held", int'(if0.held), 0);

        // Single right press for one frame
        mv0 = 0;
        btn = B_RT; frames(1); btn = 4'd0; settle(5);
        lit("tap_x", int'(if0.cell_x), 1);
        lit("tap_xt", int'(if0.x_topleft), 64);
        lit("tap_moved_count", mv0, 1);
        lit("tap_held_released", int'(if0.held), 0);

        // Continuous down: steps at frames 1, 21, 27, 33
        do_reset;
        btn = B_DN; frames(38); btn = 4'd0; settle(5);
        lit("hold_y", int'(if0.cell_y), 4);
        lit("hold_yt", int'(if0.y_topleft), 256);

        // Edges: clamp vs wrap
        do_reset; mv0 = 0;
        btn = B_UP; frames(2); btn = 4'd0; settle(5);
        lit("clamp_up_y", int'(if0.cell_y), 0);
        lit("wrap_up_y", int'(if1.cell_y), 6);
        btn = B_LT; frames(2); btn = 4'd0; settle(5);
        lit("clamp_left_x", int'(if0.cell_x), 0);
        lit("wrap_left_x", int'(if1.cell_x), 9);
        lit("wrap_left_xt", int'(if1.x_topleft), 576);
        lit("clamp_no_moved", mv0, 0);
        btn = B_RT; frames(70); btn = 4'd0; settle(5);
        lit("clamp_right_x", int'(if0.cell_x), 9);
        lit("clamp_right_moves", mv0, 9);

        // Priority and latched direction
        do_reset;
        for (int i = 0; i < 3; i++) begin
            btn = B_DN; frames(1); btn = 4'd0; settle(4);
        end
        btn = B_UP | B_RT; frames(1);
        lit("prio_y", int'(if0.cell_y), 2);
        lit("prio_x", int'(if0.cell_x), 0);
        btn = B_UP | B_DN | B_RT; frames(20);
        lit("latched_up_y", int'(if0.cell_y), 1);
        btn = 4'd0; settle(4);
        btn = B_RT; frames(1);
        btn = B_RT | B_UP; frames(20); btn = 4'd0; settle(5);
        lit("latched_right_x", int'(if0.cell_x), 2);
        lit("latched_right_y", int'(if0.cell_y), 1);

        // Reset while auto-repeating with the button still held
        do_reset;
        btn = B_DN; frames(25); settle(3);
        do_reset;
        lit("rst_rep_y", int'(if0.cell_y), 0);
        lit("rst_rep_held", int'(if0.held), 0);
        settle(3);
        frames(1);
        lit("rst_rep_fresh_y", int'(if0.cell_y), 1);
        btn = 4'd0; settle(5);

        // A press that starts and ends between frame ticks is ignored
        do_reset; mv0 = 0;
        settle(2); btn = B_RT; settle(4); btn = 4'd0;
        frames(2);
        lit("blip_x", int'(if0.cell_x), 0);
        lit("blip_moved", mv0, 0);

        // Randomized presses, releases, mid-frame blips and resets
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_reset;
            end else begin
                btn = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) btn = 4'd0;
                if ($urandom_range(0, 4) == 0) begin
                    settle($urandom_range(1, 4));
                    btn = 4'($urandom_range(0, 15));
                end
                frames($urandom_range(1, 25));
            end
        end
        btn = 4'd0; settle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
